// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: arbitrates write and read bursts to an SDRAM controller.
// Tracks a circular start pointer per direction, alternates grants when both
// directions are eligible and aborts a burst whose end pulse never arrives.
module sdram_burst_sched #(
    parameter int ADDR_W        = 23,
    parameter int CNT_W         = 10,
    parameter int RD_FIFO_DEPTH = 1024,
    parameter int TIMEOUT       = 4095
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic              read_valid,
    input  logic [CNT_W-1:0]  wr_fifo_num,
    input  logic [CNT_W-1:0]  rd_fifo_num,
    input  logic [7:0]        burst_len,
    input  logic [ADDR_W-1:0] sdram_wr_b_addr,
    input  logic [ADDR_W-1:0] sdram_wr_e_addr,
    input  logic [ADDR_W-1:0] sdram_rd_b_addr,
    input  logic [ADDR_W-1:0] sdram_rd_e_addr,
    input  logic              sdram_wr_end,
    input  logic              sdram_rd_end,
    output logic              wr_req,
    output logic              rd_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              timeout_err
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [TO_W-1:0]   to_cnt, to_cnt_nx;
    logic              last_rd, last_rd_nx;      // 1: most recent grant was read
    logic              timeout_err_nx;
    logic [ADDR_W-1:0] wr_addr_nx, rd_addr_nx;
    logic [CNT_W:0]    len_ext;
    logic [CNT_W:0]    rd_sum;
    logic              len_ok, wr_elig, rd_elig, to_hit;

    // Advance a region pointer by one burst, wrapping to the region start once
    // the next start would reach or pass the region end. The extra bit keeps
    // the sum from wrapping near the top of the address space.
    function automatic logic [ADDR_W-1:0] next_ptr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] b_addr,
        input logic [ADDR_W-1:0] e_addr,
        input logic [7:0]        len
    );
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, addr} + (ADDR_W+1)'(len);
        if (nxt >= {1'b0, e_addr}) begin
            return b_addr;
        end
        return nxt[ADDR_W-1:0];
    endfunction

    assign len_ext = (CNT_W+1)'(burst_len);
    assign rd_sum  = {1'b0, rd_fifo_num} + len_ext;
    assign len_ok  = (burst_len != 8'd0);
    assign wr_elig = init_end & len_ok & ({1'b0, wr_fifo_num} >= len_ext);
    assign rd_elig = init_end & read_valid & len_ok &
                     (rd_sum <= (CNT_W+1)'(RD_FIFO_DEPTH));
    assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));

    assign wr_req = (state == WR_BURST);
    assign rd_req = (state == RD_BURST);
    assign busy   = (state != IDLE);

    // Next-state, grant arbitration, pointer advance and timeout detection
    always_comb begin
        state_nx       = state;
        to_cnt_nx      = '0;
        last_rd_nx     = last_rd;
        timeout_err_nx = timeout_err;
        wr_addr_nx     = wr_addr;
        rd_addr_nx     = rd_addr;
        if (!init_end) begin
            state_nx   = IDLE;
            wr_addr_nx = sdram_wr_b_addr;
            rd_addr_nx = sdram_rd_b_addr;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_elig && (!rd_elig || last_rd)) begin
                        state_nx   = WR_BURST;
                        last_rd_nx = 1'b0;
                    end else if (rd_elig) begin
                        state_nx   = RD_BURST;
                        last_rd_nx = 1'b1;
                    end
                end
                WR_BURST: begin
                    if (sdram_wr_end) begin
                        state_nx   = IDLE;
                        wr_addr_nx = next_ptr(wr_addr, sdram_wr_b_addr,
                                              sdram_wr_e_addr, burst_len);
                    end else if (to_hit) begin
                        state_nx       = IDLE;
                        timeout_err_nx = 1'b1;
                    end else begin
                        to_cnt_nx = to_cnt + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (sdram_rd_end) begin
                        state_nx   = IDLE;
                        rd_addr_nx = next_ptr(rd_addr, sdram_rd_b_addr,
                                              sdram_rd_e_addr, burst_len);
                    end else if (to_hit) begin
                        state_nx       = IDLE;
                        timeout_err_nx = 1'b1;
                    end else begin
                        to_cnt_nx = to_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, pointers, timeout counter and grant history registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            to_cnt      <= '0;
            last_rd     <= 1'b1;
            timeout_err <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
        end else begin
            state       <= state_nx;
            to_cnt      <= to_cnt_nx;
            last_rd     <= last_rd_nx;
            timeout_err <= timeout_err_nx;
            wr_addr     <= wr_addr_nx;
            rd_addr     <= rd_addr_nx;
        end
    end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Testbench for sdram_burst_sched: scoreboard of expected grants (direction
// and start address) checked as the scheduler raises each request.
module tb_sdram_burst_sched;

    localparam int ADDR_W = 23;
    localparam int CNT_W  = 10;
    localparam logic [ADDR_W-1:0] WR_B = 23'h000000;
    localparam logic [ADDR_W-1:0] WR_E = 23'h000040;
    localparam logic [ADDR_W-1:0] RD_B = 23'h000100;
    localparam logic [ADDR_W-1:0] RD_E = 23'h000140;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              init_end;
    logic              read_valid;
    logic [CNT_W-1:0]  wr_fifo_num;
    logic [CNT_W-1:0]  rd_fifo_num;
    logic [7:0]        burst_len;
    logic [ADDR_W-1:0] wr_b, wr_e, rd_b, rd_e;
    logic              wr_end, rd_end;
    logic              wr_req, rd_req, busy, timeout_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    typedef struct packed {
        logic              dir;   // 0 = write, 1 = read
        logic [ADDR_W-1:0] addr;
    } burst_t;

    burst_t            exp_q[$];
    logic [ADDR_W-1:0] m_wr_ptr, m_rd_ptr;
    int                vectors    = 0;
    int                miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_burst_sched #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_FIFO_DEPTH(1024), .TIMEOUT(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .read_valid(read_valid), .wr_fifo_num(wr_fifo_num),
        .rd_fifo_num(rd_fifo_num), .burst_len(burst_len),
        .sdram_wr_b_addr(wr_b), .sdram_wr_e_addr(wr_e),
        .sdram_rd_b_addr(rd_b), .sdram_rd_e_addr(rd_e),
        .sdram_wr_end(wr_end), .sdram_rd_end(rd_end),
        .wr_req(wr_req), .rd_req(rd_req), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Reference pointer advance with wrap at the region end
    function automatic logic [ADDR_W-1:0] model_adv(input logic [ADDR_W-1:0] p,
                                                    input logic [ADDR_W-1:0] b,
                                                    input logic [ADDR_W-1:0] e,
                                                    input int len);
        longint n;
        n = longint'(p) + longint'(len);
        if (n >= longint'(e)) return b;
        return ADDR_W'(n);
    endfunction

    // Wait (bounded) for either request to rise; sampled on falling edges
    task automatic wait_req(output bit got, output bit dir, output int lat);
        got = 1'b0; dir = 1'b0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge sys_clk);
            lat++;
            if (wr_req || rd_req) begin
                got = 1'b1;
                dir = rd_req;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; init_end = 1'b1; wr_fifo_num = 10'd16;
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (wr_req !== 1'b0 || rd_req !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: wr_req=%b rd_req=%b busy=%b terr=%b required all 0",
                     wr_req, rd_req, busy, timeout_err);
        end
        vectors++;
        if (wr_addr !== '0 || rd_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: wr_addr=%0h rd_addr=%0h required 0 0", wr_addr, rd_addr);
        end
        init_end = 1'b0; sys_rst_n = 1'b1;
        @(negedge sys_clk);
        vectors++;
        if (wr_addr !== WR_B || rd_addr !== RD_B) begin
            miscompares++;
            $display("FAIL preinit_load: wr_addr=%0h rd_addr=%0h required %0h %0h",
                     wr_addr, rd_addr, WR_B, RD_B);
        end
        begin
            bit seen;
            seen = 1'b0;
            repeat (4) begin
                @(negedge sys_clk);
                if (wr_req || rd_req) seen = 1'b1;
            end
            vectors++;
            if (seen !== 1'b0) begin
                miscompares++;
                $display("FAIL preinit_noreq: request seen=%b required 0", seen);
            end
        end
        wr_fifo_num = '0;
    endtask

    task automatic test_write_single();
        burst_t e;
        init_end = 1'b1;
        @(negedge sys_clk);
        m_wr_ptr = WR_B;
        exp_q.push_back({1'b0, m_wr_ptr});
        wr_fifo_num = 10'd16;
        @(negedge sys_clk);
        e = exp_q.pop_front();
        vectors++;
        if (wr_req !== 1'b1 || busy !== 1'b1 || rd_req !== 1'b0 || wr_addr !== e.addr) begin
            miscompares++;
            $display("FAIL wr_first: wr_req=%b busy=%b rd_req=%b wr_addr=%0h required 1 1 0 %0h",
                     wr_req, busy, rd_req, wr_addr, e.addr);
        end
        @(negedge sys_clk);
        vectors++;
        if (wr_req !== 1'b1 || wr_addr !== e.addr) begin
            miscompares++;
            $display("FAIL wr_hold: wr_req=%b wr_addr=%0h required 1 %0h", wr_req, wr_addr, e.addr);
        end
        wr_end = 1'b1;
        @(negedge sys_clk);
        wr_end = 1'b0; wr_fifo_num = '0;
        m_wr_ptr = model_adv(m_wr_ptr, WR_B, WR_E, 16);
        vectors++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || wr_addr !== m_wr_ptr) begin
            miscompares++;
            $display("FAIL wr_end: wr_req=%b busy=%b wr_addr=%0h required 0 0 %0h",
                     wr_req, busy, wr_addr, m_wr_ptr);
        end
    endtask

    task automatic test_wrap();
        bit got, dir; int lat; burst_t e;
        init_end = 1'b0;
        @(negedge sys_clk);
        init_end = 1'b1;
        m_wr_ptr = WR_B;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, m_wr_ptr});
            m_wr_ptr = model_adv(m_wr_ptr, WR_B, WR_E, 16);
        end
        wr_fifo_num = 10'd16;
        for (int i = 0; i < 4; i++) begin
            wait_req(got, dir, lat);
            e = exp_q.pop_front();
            vectors++;
            if (!got || dir !== e.dir || wr_addr !== e.addr) begin
                miscompares++;
                $display("FAIL wrap_grant%0d: got=%b dir=%b wr_addr=%0h required 1 %b %0h",
                         i, got, dir, wr_addr, e.dir, e.addr);
            end
            wr_end = 1'b1;
            @(negedge sys_clk);
            wr_end = 1'b0;
            if (i == 3) wr_fifo_num = '0;
            vectors++;
            if (wr_req !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_gap%0d: wr_req=%b busy=%b required 0 0", i, wr_req, busy);
            end
        end
        @(negedge sys_clk);
        vectors++;
        if (wr_addr !== m_wr_ptr || wr_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_final: wr_addr=%0h wr_req=%b required %0h 0", wr_addr, wr_req, m_wr_ptr);
        end
    endtask

    task automatic test_alternate();
        bit got, dir; int lat; burst_t e; logic [ADDR_W-1:0] obs;
        sys_rst_n = 1'b0; init_end = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        m_wr_ptr = WR_B; m_rd_ptr = RD_B;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                exp_q.push_back({1'b0, m_wr_ptr});
                m_wr_ptr = model_adv(m_wr_ptr, WR_B, WR_E, 16);
            end else begin
                exp_q.push_back({1'b1, m_rd_ptr});
                m_rd_ptr = model_adv(m_rd_ptr, RD_B, RD_E, 16);
            end
        end
        wr_fifo_num = 10'd32; rd_fifo_num = '0; read_valid = 1'b1; init_end = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_req(got, dir, lat);
            e = exp_q.pop_front();
            obs = dir ? rd_addr : wr_addr;
            vectors++;
            if (!got || (wr_req && rd_req) || dir !== e.dir || obs !== e.addr) begin
                miscompares++;
                $display("FAIL alt_grant%0d: got=%b wr=%b rd=%b addr=%0h required dir=%b addr=%0h",
                         i, got, wr_req, rd_req, obs, e.dir, e.addr);
            end
            if (dir) rd_end = 1'b1; else wr_end = 1'b1;
            @(negedge sys_clk);
            wr_end = 1'b0; rd_end = 1'b0;
            if (i == 5) begin
                wr_fifo_num = '0; read_valid = 1'b0;
            end
            vectors++;
            if (wr_req !== 1'b0 || rd_req !== 1'b0) begin
                miscompares++;
                $display("FAIL alt_gap%0d: wr_req=%b rd_req=%b required 0 0", i, wr_req, rd_req);
            end
        end
    endtask

    task automatic test_rd_threshold();
        bit seen;
        wr_fifo_num = '0; burst_len = 8'd16; rd_fifo_num = 10'd1009; read_valid = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge sys_clk);
            if (rd_req) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_full_1009: rd_req seen=%b required 0", seen);
        end
        rd_fifo_num = 10'd1008;
        @(negedge sys_clk);
        vectors++;
        if (rd_req !== 1'b1 || rd_addr !== m_rd_ptr) begin
            miscompares++;
            $display("FAIL rd_ok_1008: rd_req=%b rd_addr=%0h required 1 %0h", rd_req, rd_addr, m_rd_ptr);
        end
        rd_end = 1'b1;
        @(negedge sys_clk);
        rd_end = 1'b0; read_valid = 1'b0; rd_fifo_num = 10'd1009;
        m_rd_ptr = model_adv(m_rd_ptr, RD_B, RD_E, 16);
        vectors++;
        if (rd_req !== 1'b0 || rd_addr !== m_rd_ptr) begin
            miscompares++;
            $display("FAIL rd_wrap: rd_req=%b rd_addr=%0h required 0 %0h", rd_req, rd_addr, m_rd_ptr);
        end
    endtask

    task automatic test_timeout();
        bit got, dir; int lat; int cnt;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL terr_pre: timeout_err=%b required 0", timeout_err);
        end
        wr_fifo_num = 10'd16;
        wait_req(got, dir, lat);
        wr_fifo_num = '0;
        cnt = (got && !dir) ? 1 : 0;
        for (int i = 0; i < 30 && cnt > 0; i++) begin
            @(negedge sys_clk);
            if (wr_req) cnt++;
            else break;
        end
        vectors++;
        if (cnt !== 8 || timeout_err !== 1'b1 || busy !== 1'b0 || wr_addr !== m_wr_ptr) begin
            miscompares++;
            $display("FAIL timeout: cycles=%0d terr=%b busy=%b wr_addr=%0h required 8 1 0 %0h",
                     cnt, timeout_err, busy, wr_addr, m_wr_ptr);
        end
        wr_end = 1'b1; rd_end = 1'b1;
        @(negedge sys_clk);
        wr_end = 1'b0; rd_end = 1'b0;
        repeat (5) @(negedge sys_clk);
        vectors++;
        if (timeout_err !== 1'b1 || wr_addr !== m_wr_ptr || rd_addr !== m_rd_ptr) begin
            miscompares++;
            $display("FAIL idle_end_sticky: terr=%b wr_addr=%0h rd_addr=%0h required 1 %0h %0h",
                     timeout_err, wr_addr, rd_addr, m_wr_ptr, m_rd_ptr);
        end
    endtask

    task automatic test_reset_mid_rd();
        bit got, dir; int lat;
        rd_fifo_num = '0; read_valid = 1'b1;
        wait_req(got, dir, lat);
        vectors++;
        if (!got || dir !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rd_start: got=%b dir=%b busy=%b required 1 1 1", got, dir, busy);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (rd_req !== 1'b0 || busy !== 1'b0 || rd_addr !== '0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_rd: rd_req=%b busy=%b rd_addr=%0h terr=%b required 0 0 0 0",
                     rd_req, busy, rd_addr, timeout_err);
        end
        read_valid = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n = 1'b0; init_end = 1'b0; read_valid = 1'b0;
        wr_fifo_num = '0; rd_fifo_num = '0; burst_len = 8'd16;
        wr_b = WR_B; wr_e = WR_E; rd_b = RD_B; rd_e = RD_E;
        wr_end = 1'b0; rd_end = 1'b0;
        m_wr_ptr = WR_B; m_rd_ptr = RD_B;
        @(negedge sys_clk);
        test_reset();
        test_write_single();
        test_wrap();
        test_alternate();
        test_rd_threshold();
        test_timeout();
        test_reset_mid_rd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
